// File: rtl/uart_rx_frame.sv
// uart_rx_frame: fixed-width UART frame receiver.
// Frame on rx: start (0), DATA_WIDTH data bits LSB first, [even parity], stop (1).
// `ready` is a level flag. It rises on a good stop bit and clears on the next confirmed start bit.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
// DATA_WIDTH must be at least 2, and CLOCKS_PER_PULSE must be at least 4.
//
// Handshake: there is no backpressure. Downstream detects the rising edge of `ready`
// and captures `data_output`, which stays stable until the next good frame.
module uart_rx_frame #(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int DATA_WIDTH       = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  busy,
  output logic                  frame_err,
  output logic [2:0]            dbg_state_o
);

  localparam int BW   = $clog2(CLOCKS_PER_PULSE);
  localparam int BITW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0]   BAUD_MID  = BW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BITW-1:0] BIT_LAST  = BITW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [BW-1:0]         baud_q, baud_d;
  logic [BITW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  ferr_q, ferr_d;
  logic                  busy_q;
  logic                  stop_ok;
`ifdef UART_RX_PARITY_EN
  logic                  par_err_q, par_err_d;
`endif

  // Two-flop synchroniser for the asynchronous line; it idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // A frame is accepted only on a high stop bit and, if enabled, good parity.
`ifdef UART_RX_PARITY_EN
  assign stop_ok = rx_s_q & ~par_err_q;
`else
  assign stop_ok = rx_s_q;
`endif

  // Next-state logic: baud and bit counting, shifting, and output updates.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (baud_q == BAUD_MID) begin
          baud_d = '0;
          if (rx_s_q) begin
            // Line is high again at mid-bit, so this was a glitch.
            state_d = S_IDLE;
          end else begin
            ready_d = 1'b0;
            bit_d   = '0;
            state_d = S_DATA;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          par_err_d = (^shift_q) ^ rx_s_q;
          state_d   = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = S_IDLE;
          if (stop_ok) begin
            data_d  = shift_q;
            ready_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign ready       = ready_q;
  assign data_output = data_q;
  assign busy        = busy_q;
  assign frame_err   = ferr_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial receiver for the bus bridge front end: deserialises one fixed-width UART frame (start, DATA_WIDTH data bits LSB-first, optional parity, stop) from the `rx` pin.
- Presents the frame as a parallel word with a level `ready` flag.
- Downstream logic detects the rising edge of `ready` and enqueues `data_output` as {mode, data, addr}.

Parameters:
- CLOCKS_PER_PULSE, 5208, clk cycles per bit period; must be >= 4.
- DATA_WIDTH, 21, payload bits per frame (bridge uses 1 + 8 + 12).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- ready  output  1  high from a good stop bit until the next confirmed start bit.
- data_output  output  DATA_WIDTH  last good frame, LSB = first data bit received.
- busy  output  1  high while the FSM is outside IDLE.
- frame_err  output  1  one-cycle pulse on a bad stop bit (or bad parity, see Optional Feature).

Behaviour:
- rx synchroniser
  - Two-flop synchroniser; both flops reset to 1.
  - The FSM uses only the synchronised `rx_s`.
- Counters
  - Baud counter width $clog2(CLOCKS_PER_PULSE), counts 0..CLOCKS_PER_PULSE-1.
  - Bit counter width $clog2(DATA_WIDTH+1).
  - Shift register DATA_WIDTH bits; shifts right, new bit enters at the MSB.
- IDLE
  - Baud counter = 0.
  - On `rx_s` == 0 -> START.
- START
  - Count to CLOCKS_PER_PULSE/2 - 1 (mid-bit), then sample `rx_s`.
  - If 1: false start -> IDLE. `ready` and `data_output` unchanged.
  - If 0: valid start. Clear `ready`, clear baud and bit counters -> DATA.
- DATA
  - Each time the baud counter reaches CLOCKS_PER_PULSE-1: sample `rx_s` into the shift register, increment the bit counter, reset the baud counter.
  - After the DATA_WIDTH-th sample -> STOP (or PARITY when enabled).
- STOP
  - After CLOCKS_PER_PULSE cycles, sample `rx_s`.
  - If 1: `data_output` <= shift register, `ready` <= 1.
  - If 0: `frame_err` pulses for 1 cycle; `data_output` is held and `ready` stays 0.
  - Either way -> IDLE.
- Latency
  - `ready` rises 2 + CLOCKS_PER_PULSE/2 + (DATA_WIDTH+1)*CLOCKS_PER_PULSE cycles (+/-1) after the rx falling edge.
  - Without parity, this is the mid-point of the stop bit.
  - Back-to-back frames with no idle gap are accepted: IDLE is re-entered mid-stop-bit, ahead of the next start edge.
- Output definitions
  - `ready` is a level, not a pulse. It is cleared only by a confirmed start bit or by reset.
  - `busy` = (state != IDLE), registered.
- Reset (any time, including mid-frame)
  - Next cycle: state = IDLE, counters = 0, shift register = 0.
  - Outputs: `ready` = 0, `data_output` = 0, `busy` = 0, `frame_err` = 0.
  - Synchroniser flops = 1.
  - A partial frame in progress is discarded.
- Glitch handling: an rx low pulse shorter than CLOCKS_PER_PULSE/2 is rejected as a false start.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - PARITY state between DATA and STOP samples one even-parity bit after CLOCKS_PER_PULSE cycles.
  - Required: XOR of data bits and parity bit = 0.
  - On mismatch, the frame is still taken through STOP, then dropped: `frame_err` pulses in the STOP-sample cycle, `data_output` is held, `ready` stays 0.
  - Frame length is 1 + DATA_WIDTH + 1 + 1 bits; `ready` latency grows by CLOCKS_PER_PULSE.
- When undefined: no PARITY state, no parity logic; frame is 1 + DATA_WIDTH + 1 bits.

Test Plan:
- Good frame (CLOCKS_PER_PULSE=16, DATA_WIDTH=21): send 21'h1A5123 with stop=1.
  - `ready` rises once, within +/-1 cycle of 2+8+22*16 = 362 cycles after the start edge.
  - `data_output` = 21'h1A5123; `frame_err` never pulses.
- Back-to-back: send 21'h000001 then 21'h1FFFFF with no idle gap.
  - `ready` falls at the second start's mid-point, then rises again.
  - `data_output` = 21'h000001, then 21'h1FFFFF.
- Bad stop: send 21'h0ABCDE with stop=0.
  - `frame_err` high exactly 1 cycle; `ready` stays 0; `data_output` keeps its previous value (0 after reset).
- False start: 5-cycle low glitch on rx.
  - FSM returns to IDLE; `busy` drops by cycle 12; `ready` and `data_output` unchanged.
- Reset mid-frame: assert `rst` for 1 cycle at bit 10 of 21'h155555, then send 21'h0F0F0F cleanly.
  - After the reset cycle: all outputs 0.
  - Second frame then received as 21'h0F0F0F with `ready` = 1.
- UART_RX_PARITY_EN defined:
  - 21'h000003 with parity=0 -> accepted, `ready` = 1.
  - Same data with parity=1 -> `frame_err` pulse, `ready` = 0.
